// File: rtl/alu_issue.sv
// ID/EX issue slot: decodes an RV32I word into ALU operands/control and holds it
// in a single registered slot with valid/ready on both sides plus flush.
module alu_issue #(
  parameter int          XLEN        = 32,
  parameter int          REG_ADDR_W  = 5,
  parameter logic [31:0] LINK_OFFSET = 32'd4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [XLEN-1:0]       pc,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       alu_d1,
  output logic [XLEN-1:0]       alu_d2,
  output logic [3:0]            alu_ctrl,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  rd_we,
  output logic                  illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b1000;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]            opcode;
  logic [2:0]            f3;
  logic [6:0]            f7;
  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]       imm_i;
  logic [XLEN-1:0]       imm_s;
  logic [XLEN-1:0]       imm_u;
  logic [XLEN-1:0]       shamt;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign rd     = instr[11:7];
  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'h000};
  assign shamt  = {{(XLEN-5){1'b0}}, instr[24:20]};

  logic [XLEN-1:0] dec_d1;
  logic [XLEN-1:0] dec_d2;
  logic [3:0]      dec_ctrl;
  logic            dec_we;
  logic            dec_ill;

  always_comb begin
    dec_d1   = '0;
    dec_d2   = '0;
    dec_ctrl = ALU_ADD;
    dec_we   = 1'b0;
    dec_ill  = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_d1   = rs1_data;
        dec_d2   = rs2_data;
        dec_ctrl = {f7[5], f3};
        dec_we   = 1'b1;
        if (!(f7 == F7_ZERO || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))))
          dec_ill = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_d1   = rs1_data;
        dec_d2   = imm_i;
        dec_ctrl = {1'b0, f3};
        dec_we   = 1'b1;
        // Shift immediates carry only the 5-bit shift amount; funct7 selects SRAI.
        if (f3 == 3'b001) begin
          dec_d2 = shamt;
          if (f7 != F7_ZERO) dec_ill = 1'b1;
        end else if (f3 == 3'b101) begin
          dec_d2   = shamt;
          dec_ctrl = {f7[5], 3'b101};
          if (f7 != F7_ZERO && f7 != F7_ALT) dec_ill = 1'b1;
        end
      end
      OPC_LOAD: begin
        dec_d1 = rs1_data;
        dec_d2 = imm_i;
        dec_we = 1'b1;
      end
      OPC_STORE: begin
        dec_d1 = rs1_data;
        dec_d2 = imm_s;
      end
      OPC_BRANCH: begin
        dec_d1 = rs1_data;
        dec_d2 = rs2_data;
        case (f3[2:1])
          2'b00:   dec_ctrl = ALU_SUB;
          2'b10:   dec_ctrl = ALU_SLT;
          2'b11:   dec_ctrl = ALU_SLTU;
          default: dec_ill  = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec_d2 = imm_u;
        dec_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec_d1 = pc;
        dec_d2 = imm_u;
        dec_we = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec_d1 = pc;
        dec_d2 = LINK_OFFSET[XLEN-1:0];
        dec_we = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_d1   = '0;
      dec_d2   = '0;
      dec_ctrl = ALU_ADD;
      dec_we   = 1'b0;
    end
    if (rd == '0) dec_we = 1'b0;
  end

  // valid/ready: a transfer occurs on a rising edge where valid && ready; the producer
  // holds its payload stable while valid && !ready. Flush blocks capture this cycle.
  logic capture;
  assign in_ready = !flush && (!out_valid || out_ready);
  assign capture  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_d1    <= '0;
      alu_d2    <= '0;
      alu_ctrl  <= ALU_ADD;
      rd_addr   <= '0;
      rd_we     <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      alu_d1    <= dec_d1;
      alu_d2    <= dec_d2;
      alu_ctrl  <= dec_ctrl;
      rd_addr   <= rd;
      rd_we     <= dec_we;
      illegal   <= dec_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
